// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, requester ids
// and the tie-break rule between the two requesters.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_t;

  // Data wins unless the fetch side has already been passed over the maximum
  // number of times; with no data request the fetch side is the only candidate.
  function automatic port_id_t pick_port(input logic d_req, input logic starved);
    return (d_req && !starved) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory, one access
// at a time, with data priority bounded by a fetch-starvation streak counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  localparam int unsigned   SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state;
  logic [SW-1:0] streak;
  logic          any_req;
  logic          starved;
  port_id_t      winner;

  always_comb begin
    any_req = i_req | d_req;
    starved = i_req && (streak == STREAK_MAX);
    winner  = pick_port(d_req, starved);
    busy    = (state != IDLE);
  end

  // The mem_* registers double as the request latch: they are loaded at the
  // grant decision and held untouched until mem_ready is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!i_req || winner == PORT_I) begin
            streak <= '0;
          end else if (streak != STREAK_MAX) begin
            streak <= streak + SW'(1);
          end
          if (any_req) begin
            mem_req <= 1'b1;
            if (winner == PORT_D) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              state     <= GRANT_D;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= i_addr;
              state    <= GRANT_I;
            end
          end
        end
        GRANT_I: begin
          if (mem_ready) begin
            i_rdata <= mem_rdata;
            mem_req <= 1'b0;
            i_ready <= 1'b1;
            state   <= RESP;
          end
        end
        GRANT_D: begin
          if (mem_ready) begin
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_ready <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model (memory image, grant order, streak).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int          STARVE = 3;
  localparam port_id_t    STARVE_ORDER [6] = '{PORT_D, PORT_D, PORT_D, PORT_I, PORT_D, PORT_D};

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [DW-1:0] tbmem   [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  bit            i_pend, d_pend, i_done, d_done;
  logic [AW-1:0] i_a, d_a;
  logic          d_w;
  logic [DW-1:0] d_wd, i_last, d_last;
  int            i_wait, d_wait;
  int unsigned   i_pulses, d_pulses;

  bit            m_active, m_started, stray;
  port_id_t      m_port;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  int            m_cnt, fixed_lat;

  int            streak_m;
  port_id_t      grants[$];
  bit            auto_i, auto_d, d_repeat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [DW-1:0] tb_read(input logic [AW-1:0] a);
    if (tbmem.exists(a)) return tbmem[a];
    return init_val(a);
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom_range(0, 15)) << 2;
  endfunction

  task automatic issue_fetch(input logic [AW-1:0] a);
    i_pend = 1; i_req = 1'b1; i_addr = a; i_a = a; i_wait = 0;
    streak_m = 0;
  endtask

  task automatic issue_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_pend = 1; d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    d_w = we; d_a = a; d_wd = wd; d_wait = 0;
  endtask

  task automatic issue_rand_data();
    issue_data(1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
  endtask

  // One clock of the bench: memory responder, grant-order model, requesters.
  task automatic step();
    bit was_ready, pi, pd, exp_d;
    @(posedge clk);
    #1;
    was_ready = mem_ready;
    pi = i_req;
    pd = d_req;
    i_done = 0;
    d_done = 0;

    if (m_active) begin
      if (was_ready) begin
        m_active = 0;
        check("mem_req_drop", 64'(mem_req), 64'(0));
        check("i_ready_after_mem", 64'(i_ready), 64'(m_port == PORT_I));
        check("d_ready_after_mem", 64'(d_ready), 64'(m_port == PORT_D));
      end else begin
        check("mem_req_held", 64'(mem_req), 64'(1));
        check("mem_addr_held", 64'(mem_addr), 64'(m_addr));
        check("mem_we_held", 64'(mem_we), 64'(m_we));
        if (m_we) check("mem_wdata_held", 64'(mem_wdata), 64'(m_wdata));
        check("busy_in_access", 64'(busy), 64'(1));
      end
    end else if (mem_req) begin
      if (!(pi || pd)) begin
        check("mem_req_unrequested", 64'(mem_req), 64'(0));
      end else begin
        exp_d   = pd && !(pi && streak_m == STARVE);
        m_port  = exp_d ? PORT_D : PORT_I;
        m_we    = exp_d ? d_w : 1'b0;
        m_addr  = exp_d ? d_a : i_a;
        m_wdata = d_wd;
        check("grant_we", 64'(mem_we), 64'(m_we));
        check("grant_addr", 64'(mem_addr), 64'(m_addr));
        if (m_we) check("grant_wdata", 64'(mem_wdata), 64'(m_wdata));
        grants.push_back(m_port);
        if (exp_d) begin
          if (pi && streak_m < STARVE) streak_m++;
        end else begin
          streak_m = 0;
        end
        m_active  = 1;
        m_started = 1;
        m_cnt     = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 5));
      end
    end

    mem_ready = 1'b0;
    mem_rdata = DW'($urandom);
    if (m_active && !m_started) begin
      if (m_cnt <= 1) begin
        mem_ready = 1'b1;
        if (m_we) tbmem[m_addr] = m_wdata;
        else      mem_rdata = tb_read(m_addr);
      end else begin
        m_cnt--;
      end
    end
    m_started = 0;
    if (stray && !m_active) begin
      mem_ready = 1'b1;
      stray = 0;
    end

    if (i_ready) begin
      i_pulses++;
      check("i_ready_expected", 64'(i_pend), 64'(1));
      if (i_pend) begin
        i_last = ref_read(i_a);
        check("i_rdata", 64'(i_rdata), 64'(i_last));
        i_pend = 0; i_req = 1'b0; i_done = 1;
      end
    end else begin
      check("i_rdata_hold", 64'(i_rdata), 64'(i_last));
      if (i_pend) begin
        i_wait++;
        if (i_wait > 80) begin
          check("fetch_wait_cycles", 64'(i_wait), 64'(80));
          i_pend = 0; i_req = 1'b0;
        end
      end
    end

    if (d_ready) begin
      d_pulses++;
      check("d_ready_expected", 64'(d_pend), 64'(1));
      if (d_pend) begin
        if (d_w) begin
          check("d_rdata_on_write", 64'(d_rdata), 64'(d_last));
          ref_mem[d_a] = d_wd;
        end else begin
          d_last = ref_read(d_a);
          check("d_rdata", 64'(d_rdata), 64'(d_last));
        end
        d_pend = 0; d_req = 1'b0; d_done = 1;
      end
    end else begin
      check("d_rdata_hold", 64'(d_rdata), 64'(d_last));
      if (d_pend) begin
        d_wait++;
        if (d_wait > 80) begin
          check("data_wait_cycles", 64'(d_wait), 64'(80));
          d_pend = 0; d_req = 1'b0;
        end
      end
    end

    if (d_done && d_repeat) issue_rand_data();
    if (auto_i && !i_pend && $urandom_range(0, 3) == 0) issue_fetch(rand_addr());
    if (auto_d && !d_pend && $urandom_range(0, 2) == 0) issue_rand_data();
  endtask

  task automatic wait_port(input port_id_t p, input int limit, output int n);
    bit seen;
    seen = 0;
    n = 0;
    while (!seen && n < limit) begin
      step();
      n++;
      seen = (p == PORT_I) ? i_done : d_done;
    end
    if (!seen) check("ready_seen", 64'(seen), 64'(1));
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((i_pend || d_pend || m_active) && n < limit) begin
      step();
      n++;
    end
    if (i_pend || d_pend || m_active) check("drain_idle", 64'(i_pend | d_pend | m_active), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    i_pend = 0; d_pend = 0; m_active = 0; m_started = 0; stray = 0;
    streak_m = 0; i_last = '0; d_last = '0;
    @(posedge clk);
    #1;
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_d_ready", 64'(d_ready), 64'(0));
    check("rst_i_ready", 64'(i_ready), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    @(posedge clk);
    #1;
    check("rst_i_rdata", 64'(i_rdata), 64'(0));
    check("rst_d_rdata", 64'(d_rdata), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int unsigned p0;
    logic [DW-1:0] d_before;

    i_addr = '0; d_we = 1'b0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    i_pulses = 0; d_pulses = 0; fixed_lat = 1;
    auto_i = 0; auto_d = 0; d_repeat = 0;
    do_reset();

    // Single fetch with 1-cycle memory
    tbmem[32'h100]   = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    step();
    issue_fetch(32'h100);
    wait_port(PORT_I, 20, n);
    check("single_fetch_latency", 64'(n), 64'(3));
    check("single_fetch_rdata", 64'(i_rdata), 64'(32'hDEAD_BEEF));
    step();
    check("i_ready_one_cycle", 64'(i_ready), 64'(0));

    // Simultaneous requests: data write first, fetch second, d_rdata kept
    fixed_lat = 2;
    issue_data(1'b0, 32'h100, '0);
    wait_port(PORT_D, 20, n);
    d_before = d_last;
    step();
    grants.delete();
    issue_fetch(32'h300);
    issue_data(1'b1, 32'h200, 32'h55);
    wait_idle(40);
    check("simul_grant_count", 64'(grants.size()), 64'(2));
    if (grants.size() >= 2) begin
      check("simul_first_data", 64'(grants[0]), 64'(PORT_D));
      check("simul_then_fetch", 64'(grants[1]), 64'(PORT_I));
    end
    check("simul_d_rdata_kept", 64'(d_rdata), 64'(d_before));

    // Starvation: continuous data traffic with a waiting fetch
    step();
    fixed_lat = 1;
    grants.delete();
    d_repeat = 1;
    issue_fetch(32'h400);
    issue_rand_data();
    n = 0;
    while (grants.size() < 6 && n < 100) begin
      step();
      n++;
    end
    d_repeat = 0;
    wait_idle(40);
    check("starve_grant_count", 64'(grants.size() >= 6), 64'(1));
    for (int k = 0; k < 6; k++) begin
      if (k < grants.size()) check("starve_order", 64'(grants[k]), 64'(STARVE_ORDER[k]));
    end

    // Variable latency: 5-cycle memory
    fixed_lat = 5;
    step();
    p0 = d_pulses;
    issue_data(1'b0, 32'h40, '0);
    wait_port(PORT_D, 30, n);
    check("lat5_latency", 64'(n), 64'(7));
    repeat (3) step();
    check("lat5_one_pulse", 64'(d_pulses - p0), 64'(1));

    // Reset while the third consecutive data grant is in flight
    grants.delete();
    d_repeat = 1;
    issue_fetch(32'h500);
    issue_data(1'b1, 32'h80, 32'hA5A5_A5A5);
    n = 0;
    while (grants.size() < 3 && n < 100) begin
      step();
      n++;
    end
    d_repeat = 0;
    p0 = d_pulses;
    do_reset();
    repeat (4) step();
    check("reset_no_d_ready", 64'(d_pulses - p0), 64'(0));
    check("reset_idle_busy", 64'(busy), 64'(0));
    fixed_lat = 1;
    grants.delete();
    issue_fetch(32'h600);
    issue_data(1'b0, 32'h80, '0);
    wait_idle(40);
    if (grants.size() >= 1) check("reset_streak_cleared", 64'(grants[0]), 64'(PORT_D));
    else check("reset_grant_count", 64'(grants.size()), 64'(2));

    // Stray mem_ready while idle
    repeat (2) step();
    p0 = i_pulses + d_pulses;
    stray = 1;
    step();
    step();
    check("stray_busy", 64'(busy), 64'(0));
    check("stray_mem_req", 64'(mem_req), 64'(0));
    step();
    check("stray_no_ready", 64'(i_pulses + d_pulses - p0), 64'(0));
    issue_fetch(32'h104);
    wait_port(PORT_I, 20, n);
    check("after_stray_latency", 64'(n), 64'(3));

    // Request dropped after the grant still completes
    fixed_lat = 3;
    step();
    issue_data(1'b0, 32'h44, '0);
    step();
    d_req = 1'b0;
    wait_port(PORT_D, 20, n);
    check("dropped_req_completes", 64'(d_done), 64'(1));

    // Random traffic with random memory latency
    fixed_lat = 0;
    auto_i = 1;
    auto_d = 1;
    repeat (2500) step();
    auto_i = 0;
    auto_d = 0;
    wait_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter STARVE_LIMIT, default 3, maximum consecutive data grants while a fetch waits.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 i_req  in  1  fetch request; held until i_ready.
REQ-007 i_addr  in  AW  fetch address; stable while i_req.
REQ-008 i_ready  out  1  one-cycle pulse: fetch complete.
REQ-009 i_rdata  out  DW  fetch data; valid with i_ready, held until the next fetch completes.
REQ-010 d_req  in  1  data request; held until d_ready.
REQ-011 d_we  in  1  data write enable; stable while d_req.
REQ-012 d_addr  in  AW  data address; stable while d_req.
REQ-013 d_wdata  in  DW  write data; stable while d_req.
REQ-014 d_ready  out  1  one-cycle pulse: data access complete.
REQ-015 d_rdata  out  DW  load data; valid with d_ready on reads, held otherwise.
REQ-016 mem_req  out  1  shared-memory request; held until mem_ready.
REQ-017 mem_we  out  1  shared-memory write.
REQ-018 mem_addr  out  AW  shared-memory address.
REQ-019 mem_wdata  out  DW  shared-memory write data.
REQ-020 mem_rdata  in  DW  memory read data; valid with mem_ready.
REQ-021 mem_ready  in  1  access complete; latency 1..N cycles after mem_req rises.
REQ-022 busy  out  1  high in any state other than IDLE.

Function
REQ-023 The FSM SHALL have exactly four states: IDLE, GRANT_I, GRANT_D, RESP.
REQ-024 In IDLE with only d_req high, the block SHALL latch d_we/d_addr/d_wdata and enter GRANT_D.
REQ-025 In IDLE with only i_req high, the block SHALL latch i_addr, force mem_we=0 and enter GRANT_I.
REQ-026 In IDLE with both requests high, data SHALL win unless streak==STARVE_LIMIT, in which case fetch wins.
REQ-027 streak SHALL increment (saturating at STARVE_LIMIT) on each data grant made while i_req is high, and SHALL clear on a fetch grant or whenever i_req is low in IDLE.
REQ-028 mem_req/mem_we/mem_addr/mem_wdata SHALL be registered from the latched request, asserted the cycle after the grant decision and held constant until mem_ready is sampled high.
REQ-029 On mem_ready in GRANT_x, the block SHALL register mem_rdata into x_rdata (reads only), drop mem_req the next cycle and enter RESP.
REQ-030 In RESP, x_ready SHALL be high for exactly one cycle; the FSM SHALL return to IDLE, and request inputs are ignored in RESP.
REQ-031 Minimum request-to-ready latency SHALL be 3 cycles with 1-cycle memory; back-to-back throughput SHALL be one access per (memory latency + 3) cycles.
REQ-032 mem_ready seen in IDLE or RESP SHALL be ignored.
REQ-033 The block SHALL NOT issue a write for a fetch and SHALL NOT modify d_rdata on a data write.
REQ-034 A request dropped before its ready SHALL still complete; the ready pulse is still issued.

Reset
REQ-035 On reset the FSM SHALL enter IDLE; mem_req, mem_we, i_ready, d_ready and busy SHALL go to 0; streak, i_rdata, d_rdata, mem_addr and mem_wdata SHALL go to 0.
REQ-036 Reset mid-access SHALL abandon the access with no ready pulse; the requester re-issues.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the state enum (IDLE, GRANT_I, GRANT_D, RESP) and a port-id enum (PORT_I, PORT_D).
REQ-038 The block SHALL be one flat module with no sub-module; it holds the FSM, the request latch, the streak counter and the response registers.

Verification
REQ-039 Single fetch: i_req=1, i_addr=0x100, mem_rdata=0xDEADBEEF with 1-cycle mem_ready -> mem_addr=0x100 with mem_we=0, then i_ready pulses 3 cycles after i_req and i_rdata=0xDEADBEEF.
REQ-040 Simultaneous requests: i_req and d_req (write 0x55 to 0x200) rise together -> data is granted first (mem_we=1, mem_addr=0x200), then the fetch; d_rdata is unchanged.
REQ-041 Starvation: d_req held continuously and i_req held -> exactly 3 data grants, then 1 fetch grant, then data resumes.
REQ-042 Variable latency: mem_ready delayed 5 cycles -> mem_req/mem_addr stay constant for 5 cycles, then exactly one ready pulse.
REQ-043 Reset mid-access: reset asserted in GRANT_D -> mem_req=0 next cycle, no d_ready pulse, busy=0, streak=0.
REQ-044 Stray mem_ready in IDLE -> no ready pulse and no state change.
